ycbcr_to_rgb: RTL
=================

Name: ycbcr_to_rgb

Overview:
- Colour-space converter for the JPEG decode path: YCbCr (JFIF full-range, 8-bit per component) back to 8-bit RGB.
- Inverse of the encoder-side RGB-to-YCbCr stage; consumes the same packed 24-bit pixel format `{y, cb, cr}`.
- 3-stage pipeline with valid/ready handshake and global stall, so it can sit between the IDCT/upsampler output and a pixel sink that may backpressure.
- Carries a per-pixel `last` sideband aligned with data.

Parameters:
- None. Coefficient format (Q8) and widths are fixed.

Ports:
- clk        input   1   rising-edge clock
- rst        input   1   synchronous reset, active-high
- in_valid   input   1   input pixel valid
- in_ready   output  1   block can accept a pixel this cycle
- in_data    input   24  `{y[23:16], cb[15:8], cr[7:0]}`, unsigned 8-bit each
- in_last    input   1   sideband, e.g. end of MCU/line; passed through unchanged
- out_valid  output  1   output pixel valid
- out_ready  input   1   sink accepts a pixel this cycle
- out_data   output  24  `{r[23:16], g[15:8], b[7:0]}`, unsigned 8-bit each
- out_last   output  1   in_last of the same pixel

Behaviour:

Reset:
- rst is sampled at the clk edge.
- Clears the stage valid bits v1, v2 and v3.
- After reset: out_valid=0, out_data=0, out_last=0, in_ready=1.
- Reset mid-stream discards every pixel in flight. No output is produced for those pixels.

Handshake:
- adv = ~v3 | out_ready.
- in_ready = adv. This is combinational from out_ready and v3.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- When adv=0, every stage register holds (global stall).
- When adv=1, all stages shift by one. v1 loads in_valid.
- out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Latency: 3 cycles from the accepting edge to out_valid, with no stalls.
- Throughput: 1 pixel/clk.
- Bubbles are not collapsed.

Stage 1 (register + offset):
- dcb = cb - 128 and dcr = cr - 128, each 9-bit signed.
- Register y, dcb, dcr and last.

Stage 2 (multiply), signed products:
- tr = 359*dcr
- tg = -88*dcb - 183*dcr (18-bit signed)
- tb = 454*dcb
- Register tr, tg, tb with y and last.

Stage 3 (round, sum, clamp):
- Rounding: each term is (t + 128) >>> 8, an arithmetic shift (floor).
- Sums (11-bit signed):
  - r = y + round(tr)
  - g = y + round(tg)
  - b = y + round(tb)
- Clamp each sum: <0 gives 0, >255 gives 255, otherwise the low 8 bits.
- The result is registered into out_data. v3 drives out_valid.

Boundary conditions:
- Neutral chroma (cb=cr=128) gives r=g=b=y exactly.
- Extreme inputs (0 or 255 on any component) must saturate and never wrap.
- Simultaneous in-transfer and out-transfer in a full pipeline is lossless.
- A stall cycle with in_valid=1 does not accept the pixel. The source must hold it until in_ready=1.

Test Plan:
1. Reset, then `in_data=0x808080`, in_last=1, out_ready=1 → out_valid exactly 3 cycles after acceptance, `out_data=0x808080`, out_last=1. After rst: out_valid=0, in_ready=1.
2. `in_data=0x000000` → `out_data=0x008800` (r clamps 0, g=136, b clamps 0). `in_data=0x64C832` (y=100, cb=200, cr=50) → `out_data=0x0083E4` (r clamps 0, g=131, b=228).
3. `in_data=0xFF80FF` (y=255, cr=255) → r clamps 255, g=164, b=255 → `0xFFA4FF`.
4. Stream 8 distinct pixels back-to-back with out_ready=1 → 8 consecutive out_valid cycles, order preserved, last only on pixel 8.
5. Streaming with out_ready toggled randomly, including 5-cycle low runs → in_ready=0 exactly when v3=1 & out_ready=0. out_data stable during stall. No pixel lost or duplicated (scoreboard against the reference formula).
6. Assert rst for 1 cycle with 3 pixels in flight → out_valid=0 next cycle, none of the 3 pixels emerge, and the next accepted pixel appears after 3 cycles.

Source files
------------

// File: rtl/ycbcr_to_rgb.sv
// ycbcr_to_rgb
//   JFIF full-range YCbCr -> RGB colour converter for the JPEG decode path.
//   Three register stages share a global stall. The stages are:
//     1) remove the chroma offset
//     2) Q8 chroma products
//     3) round, add luma, clamp
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high (clears stage valids and output)
//   in_valid   input pixel valid
//   in_ready   block accepts a pixel this cycle (= ~v3 | out_ready)
//   in_data    {y, cb, cr}, 8-bit unsigned each
//   in_last    sideband, travels with its pixel
//   out_valid  output pixel valid
//   out_ready  sink accepts a pixel this cycle
//   out_data   {r, g, b}, 8-bit unsigned each
//   out_last   in_last of the same pixel

// Per-channel stage-3 datapath: round the Q8 term, add luma, saturate.
//   y     luma of the pixel
//   term  Q8 chroma contribution for this channel (signed)
//   pix   saturated 8-bit channel value
module ycbcr_to_rgb_chan (
    input  logic        [7:0]  y,
    input  logic signed [17:0] term,
    output logic        [7:0]  pix
);
    logic signed [17:0] rnd;
    logic signed [17:0] sum;

    always_comb begin
        // Arithmetic shift gives floor(), so +128 is round-half-up.
        rnd = (term + 18'sd128) >>> 8;
        // |rnd| < 256, so the sum fits easily; the extra width just means
        // no wrap can happen before the clamp.
        sum = $signed({10'd0, y}) + rnd;
        if (sum[17])
            pix = 8'd0;
        else if (sum > 18'sd255)
            pix = 8'd255;
        else
            pix = sum[7:0];
    end
endmodule

module ycbcr_to_rgb (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic        out_last
);
    localparam int NUM_CH = 3;   // index 2 = r, 1 = g, 0 = b

    logic adv;

    // stage 1
    logic              v1;
    logic        [7:0] y1;
    logic signed [8:0] dcb1;
    logic signed [8:0] dcr1;
    logic              last1;

    // stage 2
    logic                         v2;
    logic        [7:0]            y2;
    logic [NUM_CH-1:0][17:0]      t2;
    logic                         last2;

    // stage 3 (output)
    logic                         v3;
    logic [NUM_CH-1:0][7:0]       rgb;

    // Whole pipe moves together; an empty output slot lets it advance
    // even while the sink is stalled.
    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    // Stage 1: register luma, strip the 128 offset from chroma.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            y1    <= '0;
            dcb1  <= '0;
            dcr1  <= '0;
            last1 <= 1'b0;
        end else if (adv) begin
            v1    <= in_valid;
            y1    <= in_data[23:16];
            dcb1  <= $signed({1'b0, in_data[15:8]}) - 9'sd128;
            dcr1  <= $signed({1'b0, in_data[7:0]})  - 9'sd128;
            last1 <= in_last;
        end
    end

    // Stage 2: Q8 products (1.402, -0.344/-0.714, 1.772 scaled by 256).
    always_ff @(posedge clk) begin
        if (rst) begin
            v2    <= 1'b0;
            y2    <= '0;
            t2    <= '0;
            last2 <= 1'b0;
        end else if (adv) begin
            v2    <= v1;
            y2    <= y1;
            t2[2] <= dcr1 * 18'sd359;
            t2[1] <= dcb1 * -18'sd88 - dcr1 * 18'sd183;
            t2[0] <= dcb1 * 18'sd454;
            last2 <= last1;
        end
    end

    // Stage 3: round, sum and clamp per channel.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ycbcr_to_rgb_chan u_chan (
            .y    (y2),
            .term (t2[c]),
            .pix  (rgb[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3       <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (adv) begin
            v3       <= v2;
            out_data <= rgb;
            out_last <= last2;
        end
    end
endmodule
